// File: rtl/rv_sdram_bridge.sv
// rv_sdram_bridge
// Initiator side of the SDRAM controller's RISC-V port. Splits one 32-bit
// picorv32-style memory transaction into one or two 16-bit accesses on the
// rv_* port. Each access is retried while rv_wait is high. Read halves are
// collected into mem_rdata. A single mem_ready pulse ends the transaction.
//
// Ports
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   mem_valid/mem_ready  core request level / one-cycle completion pulse
//   mem_addr[22:0]       byte address, bits [1:0] ignored
//   mem_wdata[31:0]      write data
//   mem_wstrb[3:0]       byte enables, 0000 = read
//   mem_rdata[31:0]      read data, held until the next read completes
//   rv_addr[21:0]        halfword address (byte address bits [22:1])
//   rv_din[15:0]         write halfword
//   rv_ds[1:0]           halfword byte enables, [1] = upper byte
//   rv_rd / rv_wr        read / write request levels
//   rv_wait              controller is not servicing the request this cycle
//   rv_dout[15:0]        read halfword, valid RD_LAT cycles after acceptance
//   busy                 high whenever the FSM is not idle
//   dbg_state[2:0]       current FSM state
//
// Handshake: core side, mem_valid is sampled only in IDLE and the request is
// captured on that edge; mem_ready is high for exactly one cycle (DONE).
// Controller side, an access is accepted at a clk edge where rv_rd or rv_wr
// is high and rv_wait is low; until then every rv_* output is held unchanged.

module rv_sdram_bridge #(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [22:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic [21:0] rv_addr,
    output logic [15:0] rv_din,
    output logic [1:0]  rv_ds,
    output logic        rv_rd,
    output logic        rv_wr,
    input  logic        rv_wait,
    input  logic [15:0] rv_dout,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LO_REQ  = 3'd1,
        S_LO_DATA = 3'd2,
        S_HI_REQ  = 3'd3,
        S_HI_DATA = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

    state_t      r_state;
    logic [20:0] r_addr;
    logic [15:0] r_wdata_hi;
    logic [1:0]  r_wstrb_hi;
    logic        r_is_rd;
    logic [2:0]  r_cnt;
    logic        r_mem_ready;
    logic [31:0] r_mem_rdata;
    logic [21:0] r_rv_addr;
    logic [15:0] r_rv_din;
    logic [1:0]  r_rv_ds;
    logic        r_rv_rd;
    logic        r_rv_wr;

    // Word-aligned transactions only; the byte offset is deliberately dropped.
    logic w_unused_addr_lsb;
    assign w_unused_addr_lsb = ^mem_addr[1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_wdata_hi  <= '0;
            r_wstrb_hi  <= '0;
            r_is_rd     <= 1'b0;
            r_cnt       <= '0;
            r_mem_ready <= 1'b0;
            r_mem_rdata <= '0;
            r_rv_addr   <= '0;
            r_rv_din    <= '0;
            r_rv_ds     <= '0;
            r_rv_rd     <= 1'b0;
            r_rv_wr     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_valid) begin
                        r_addr     <= mem_addr[22:2];
                        r_wdata_hi <= mem_wdata[31:16];
                        r_wstrb_hi <= mem_wstrb[3:2];
                        r_is_rd    <= (mem_wstrb == 4'b0000);
                        if (mem_wstrb == 4'b0000) begin
                            // Reads always fetch both halves with full byte enables.
                            r_rv_addr <= {mem_addr[22:2], 1'b0};
                            r_rv_din  <= mem_wdata[15:0];
                            r_rv_ds   <= 2'b11;
                            r_rv_rd   <= 1'b1;
                            r_state   <= S_LO_REQ;
                        end else if (mem_wstrb[1:0] == 2'b00) begin
                            // Upper-half-only write skips the low access entirely.
                            r_rv_addr <= {mem_addr[22:2], 1'b1};
                            r_rv_din  <= mem_wdata[31:16];
                            r_rv_ds   <= mem_wstrb[3:2];
                            r_rv_wr   <= 1'b1;
                            r_state   <= S_HI_REQ;
                        end else begin
                            r_rv_addr <= {mem_addr[22:2], 1'b0};
                            r_rv_din  <= mem_wdata[15:0];
                            r_rv_ds   <= mem_wstrb[1:0];
                            r_rv_wr   <= 1'b1;
                            r_state   <= S_LO_REQ;
                        end
                    end
                end
                S_LO_REQ: begin
                    if (!rv_wait) begin
                        r_rv_rd <= 1'b0;
                        r_rv_wr <= 1'b0;
                        if (r_is_rd) begin
                            r_cnt   <= CNT_INIT;
                            r_state <= S_LO_DATA;
                        end else if (r_wstrb_hi == 2'b00) begin
                            r_mem_ready <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_rv_addr <= {r_addr, 1'b1};
                            r_rv_din  <= r_wdata_hi;
                            r_rv_ds   <= r_wstrb_hi;
                            r_rv_wr   <= 1'b1;
                            r_state   <= S_HI_REQ;
                        end
                    end
                end
                S_LO_DATA: begin
                    if (r_cnt == 3'd0) begin
                        r_mem_rdata[15:0] <= rv_dout;
                        r_rv_addr         <= {r_addr, 1'b1};
                        r_rv_ds           <= 2'b11;
                        r_rv_rd           <= 1'b1;
                        r_state           <= S_HI_REQ;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_HI_REQ: begin
                    if (!rv_wait) begin
                        r_rv_rd <= 1'b0;
                        r_rv_wr <= 1'b0;
                        if (r_is_rd) begin
                            r_cnt   <= CNT_INIT;
                            r_state <= S_HI_DATA;
                        end else begin
                            r_mem_ready <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_HI_DATA: begin
                    if (r_cnt == 3'd0) begin
                        r_mem_rdata[31:16] <= rv_dout;
                        r_mem_ready        <= 1'b1;
                        r_state            <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_DONE: begin
                    // mem_valid is ignored here, forcing one IDLE cycle between transactions.
                    r_mem_ready <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_mem_ready <= 1'b0;
                    r_rv_rd     <= 1'b0;
                    r_rv_wr     <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_ready = r_mem_ready;
    assign mem_rdata = r_mem_rdata;
    assign rv_addr   = r_rv_addr;
    assign rv_din    = r_rv_din;
    assign rv_ds     = r_rv_ds;
    assign rv_rd     = r_rv_rd;
    assign rv_wr     = r_rv_wr;
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

endmodule

// File: doc/rv_sdram_bridge.md
Name: rv_sdram_bridge

Overview:
- Initiator side of the SDRAM controller's RISC-V port.
- Converts one 32-bit valid/ready memory transaction from the softcore (picorv32-style mem_valid/mem_ready/mem_wstrb) into one or two 16-bit accesses on the rv_* port.
- Retries each access while rv_wait is high, collects read data, then returns a single mem_ready pulse.
- Sits between the RISC-V core and the SDRAM controller's rv_addr/rv_din/rv_ds/rv_rd/rv_wr/rv_wait/rv_dout interface.

Parameters:
- RD_LAT, 2, clk cycles from read acceptance (rv_rd high and rv_wait low at a clk edge) to rv_dout valid; range 1..7.

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- mem_valid  in  1  transaction request, held until mem_ready
- mem_ready  out  1  one-cycle completion pulse
- mem_addr  in  23  byte address [22:0]; bits [1:0] ignored
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte enables; 0000 = read
- mem_rdata  out  32  read data, valid when mem_ready=1, held until next read completes
- rv_addr  out  22  halfword address [22:1] to controller
- rv_din  out  16  write halfword
- rv_ds  out  2  halfword byte enables ([1]=upper byte)
- rv_rd  out  1  read request level
- rv_wr  out  1  write request level
- rv_wait  in  1  controller not servicing request this cycle
- rv_dout  in  16  read halfword from controller
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, any state): state=IDLE; mem_ready=0, mem_rdata=0, rv_addr=0, rv_din=0, rv_ds=00, rv_rd=0, rv_wr=0, busy=0; latency counter=0. Deassertion takes effect on the next clk edge.
- Transaction capture in IDLE when mem_valid=1:
  - Latch addr[22:2], wdata, wstrb.
  - Low half uses rv_addr={addr[22:2],0}, data wdata[15:0], ds wstrb[1:0].
  - High half uses rv_addr={addr[22:2],1}, data wdata[31:16], ds wstrb[3:2].
- States:
  - IDLE: go to LO_REQ, except write with wstrb[1:0]=00 -> HI_REQ, and wstrb=0000 never occurs as a write (0000 is a read).
  - LO_REQ: drive low-half address/data/ds; rv_rd (read) or rv_wr (write) =1. At a clk edge with rv_wait=0 the access is accepted:
    - Write: drop rv_wr; go to HI_REQ, or DONE if wstrb[3:2]=00.
    - Read: drop rv_rd; load counter=RD_LAT-1; go to LO_DATA.
    - While rv_wait=1: hold all rv_* outputs unchanged, no limit on retries.
  - LO_DATA: decrement the counter each cycle. At the edge where counter=0, capture rv_dout into mem_rdata[15:0]; go to HI_REQ.
  - HI_REQ / HI_DATA: same rules as LO_REQ/LO_DATA for the high half.
    - Writes go HI_REQ -> DONE.
    - Reads go HI_DATA -> DONE, capturing into mem_rdata[31:16].
  - DONE: mem_ready=1 for exactly this cycle; next state IDLE.
- A new mem_valid is not accepted in DONE, so minimum back-to-back spacing is one IDLE cycle.
- Reads always drive rv_ds=11 and access both halves.
- rv_rd and rv_wr are never high together. Each is high only in the *_REQ states.
- mem_valid dropping mid-transaction is a protocol violation. The bridge completes the captured transaction and still pulses mem_ready.
- Changes on mem_addr/mem_wdata/mem_wstrb after capture are ignored.
- mem_rdata is unchanged by write transactions.
- Latency with rv_wait=0:
  - 32-bit write: mem_ready 3 cycles after capture edge.
  - 32-bit read: mem_ready 2*(RD_LAT+1)+1 cycles after capture edge.

Test Plan:
- Read, RD_LAT=2, rv_wait=0, mem_addr=0x000104, controller returns 0xBEEF at 0x82 and 0xDEAD at 0x83 -> rv_addr=0x000082 then 0x000083 with rv_ds=11; mem_rdata=0xDEADBEEF; mem_ready one cycle, 7 cycles after capture.
- Write wstrb=1111, addr=0x000010, wdata=0x12345678 -> rv_wr with rv_addr=0x08/din=0x5678/ds=11, then 0x09/0x1234/11; mem_ready 3 cycles after capture; mem_rdata unchanged.
- Write wstrb=0100, wdata=0xAABBCCDD -> single access only: rv_addr={addr,1}, din=0xAABB, ds=01; no low-half rv_wr ever asserted.
- Read with rv_wait=1 for 5 cycles on the low half and 3 on the high half -> rv_rd and rv_addr held stable throughout; data correct; mem_ready delayed exactly 8 cycles vs no-wait case.
- resetn pulsed low during HI_DATA of a read -> outputs immediately 0, busy=0; no mem_ready; next read after reset completes normally with correct data.
- mem_valid held continuously across two reads (addr 0x0, then 0x4) -> two separate mem_ready pulses, at least one IDLE cycle between them, mem_rdata updated each time.
